// File: rtl/div_clk_mon_pkg.sv
// Shared types and constants for the divided-clock frequency monitor.
package div_clk_mon_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned NUM_CHAN    = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    REPORT = 2'd2
  } state_t;

  typedef struct packed {
    logic       found;
    logic [1:0] chan;
  } pick_t;

  // Lowest enabled channel at or above 'from'; found=0 when none remain.
  function automatic pick_t pick_chan(input logic [3:0] mask, input logic [2:0] from);
    pick_t p;
    p = '0;
    for (int unsigned i = 0; i < NUM_CHAN; i++) begin
      if (!p.found && (i >= 32'(from)) && mask[i]) begin
        p.found = 1'b1;
        p.chan  = 2'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/div_clk_monitor_edge_sync.sv
// One-bit synchronizer for an asynchronous clock input followed by rising-edge detect.
module edge_sync
  import div_clk_mon_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic rise
);

  logic [SYNC_STAGES:0] sh;

  always_ff @(posedge clk) begin
    if (!resetn) sh <= '0;
    else         sh <= {sh[SYNC_STAGES-1:0], d};
  end

  assign rise = sh[SYNC_STAGES-1] & ~sh[SYNC_STAGES];

endmodule

// File: rtl/div_clk_monitor.sv
// Gated edge counter sweeping four divided PL clocks one channel at a time.
// Optional per-channel stuck flags are enabled with DIV_CLK_MONITOR_STUCK_EN.
module div_clk_monitor
  import div_clk_mon_pkg::*;
#(
  parameter int unsigned WINDOW_CYCLES = 1024,
  parameter int unsigned CNT_WIDTH     = 16
) (
  input  logic                 ila_clk,
  input  logic                 pl_resetn,
  input  logic [3:0]           div_clk_in,
  input  logic [3:0]           chan_mask,
  input  logic                 start,
  input  logic                 cont,
  output logic                 busy,
  output logic                 meas_valid,
  output logic [1:0]           meas_chan,
  output logic [CNT_WIDTH-1:0] meas_count
`ifdef DIV_CLK_MONITOR_STUCK_EN
  ,
  output logic [3:0]           stuck
`endif
);

  localparam logic [15:0] WIN_LAST = 16'(WINDOW_CYCLES - 1);

  state_t               state, state_n;
  logic [3:0]           rise;
  logic [3:0]           mask_q, mask_n;
  logic [1:0]           chan_q, chan_n;
  logic [15:0]          win_cnt;
  logic [CNT_WIDTH-1:0] edge_cnt;
  logic                 clr, inc, last;
  pick_t                pick;

  for (genvar g = 0; g < 4; g++) begin : g_sync
    edge_sync u_sync (
      .clk    (ila_clk),
      .resetn (pl_resetn),
      .d      (div_clk_in[g]),
      .rise   (rise[g])
    );
  end

  assign inc        = rise[chan_q] && (edge_cnt != '1);
  assign last       = (win_cnt == WIN_LAST);
  assign busy       = (state != IDLE);
  assign meas_valid = (state == REPORT);

  always_comb begin
    state_n = state;
    mask_n  = mask_q;
    chan_n  = chan_q;
    clr     = 1'b0;
    pick    = '0;
    case (state)
      IDLE: begin
        if (start && (chan_mask != '0)) begin
          pick    = pick_chan(chan_mask, 3'd0);
          mask_n  = chan_mask;
          chan_n  = pick.chan;
          clr     = 1'b1;
          state_n = GATE;
        end
      end
      GATE: begin
        if (last) state_n = REPORT;
      end
      REPORT: begin
        pick = pick_chan(mask_q, {1'b0, chan_q} + 3'd1);
        if (pick.found) begin
          chan_n  = pick.chan;
          clr     = 1'b1;
          state_n = GATE;
        end else if (cont) begin
          // Wrap: relatch the live mask; an empty mask ends the run.
          mask_n = chan_mask;
          pick   = pick_chan(chan_mask, 3'd0);
          if (pick.found) begin
            chan_n  = pick.chan;
            clr     = 1'b1;
            state_n = GATE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge ila_clk) begin
    if (!pl_resetn) begin
      state      <= IDLE;
      mask_q     <= '0;
      chan_q     <= '0;
      win_cnt    <= '0;
      edge_cnt   <= '0;
      meas_chan  <= '0;
      meas_count <= '0;
    end else begin
      state  <= state_n;
      mask_q <= mask_n;
      chan_q <= chan_n;
      if (clr) begin
        win_cnt  <= '0;
        edge_cnt <= '0;
      end else if (state == GATE) begin
        win_cnt <= win_cnt + 16'd1;
        if (inc) edge_cnt <= edge_cnt + 1'b1;
      end
      // Result includes any edge seen on the final gate cycle.
      if ((state == GATE) && last) begin
        meas_chan  <= chan_q;
        meas_count <= inc ? edge_cnt + 1'b1 : edge_cnt;
      end
    end
  end

`ifdef DIV_CLK_MONITOR_STUCK_EN
  always_ff @(posedge ila_clk) begin
    if (!pl_resetn)            stuck <= '0;
    else if (state == REPORT)  stuck[meas_chan] <= (meas_count == '0);
  end
`else
  // Stuck reporting not built.
`endif

endmodule
